// File: rtl/audio_pkg.sv
// ============================================================================
// Package  : audio_pkg
// Purpose  : Shared widths, saturation limits and FSM states for the gain ramp.
// Revision : 1.0
// ============================================================================
`default_nettype none

package audio_pkg;

  localparam int          SAMPLE_W   = 16;
  localparam int          GAIN_FRAC  = 14;
  localparam logic [15:0] UNITY_GAIN = 16'h4000;
  localparam int          SAT_MAX    = 32767;
  localparam int          SAT_MIN    = -32768;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MUL1 = 2'd2,
    ST_MUL2 = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gain_mul_sat.sv
// ============================================================================
// Module   : gain_mul_sat
// Purpose  : Combinational s16 x u16(Q2.14) multiply, round half up, clamp to int16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gain_mul_sat
  import audio_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic        [SAMPLE_W-1:0] gain_i,
  output logic signed [SAMPLE_W-1:0] result_o
);

  localparam int PROD_W = 2 * SAMPLE_W + 1;
  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(2 ** (GAIN_FRAC - 1));
  localparam logic signed [PROD_W-1:0] HI_LIM   = PROD_W'(SAT_MAX);
  localparam logic signed [PROD_W-1:0] LO_LIM   = PROD_W'(SAT_MIN);

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rounded;
  logic signed [PROD_W-1:0] shifted;

  // Gain is zero-extended so 0x8000..0xFFFF stay positive.
  assign prod    = sample_i * $signed({1'b0, gain_i});
  assign rounded = prod + RND_HALF;
  assign shifted = rounded >>> GAIN_FRAC;

  always_comb begin
    if (shifted > HI_LIM) begin
      result_o = SAMPLE_W'(SAT_MAX);
    end else if (shifted < LO_LIM) begin
      result_o = SAMPLE_W'(SAT_MIN);
    end else begin
      result_o = shifted[SAMPLE_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/audio_gain_ramp.sv
// ============================================================================
// Module   : audio_gain_ramp
// Purpose  : Frame-locked stereo gain stage with ramped Q2.14 gain and int16
//            saturation; one multiplier shared by both channels.
//            Define GAIN_RAMP_EN to limit gain change to RAMP_STEP per frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module audio_gain_ramp
  import audio_pkg::*;
#(
  parameter logic [7:0]  LOAD_CNT  = 8'd8,
  parameter logic [15:0] RAMP_STEP = 16'h0100,
  parameter logic [15:0] UNITY     = UNITY_GAIN
) (
  input  logic                mclk,
  input  logic                rst,
  input  logic [7:0]          cnt256_n,
  input  logic [SAMPLE_W-1:0] ch1_in,
  input  logic [SAMPLE_W-1:0] ch2_in,
  input  logic [15:0]         gain_target,
  input  logic                mute,
  output logic [SAMPLE_W-1:0] ch1_out,
  output logic [SAMPLE_W-1:0] ch2_out,
  output logic [15:0]         gain_cur
);

  state_t                      state_q;
  logic signed [SAMPLE_W-1:0]  smp1_q;
  logic signed [SAMPLE_W-1:0]  smp2_q;
  logic signed [SAMPLE_W-1:0]  res1_q;
  logic        [SAMPLE_W-1:0]  ch1_q;
  logic        [SAMPLE_W-1:0]  ch2_q;
  logic        [15:0]          gain_q;
  logic        [15:0]          gain_d;
  logic        [15:0]          eff_tgt;
  logic signed [SAMPLE_W-1:0]  mul_smp;
  logic signed [SAMPLE_W-1:0]  mul_res;

  assign eff_tgt = mute ? 16'h0000 : gain_target;

`ifdef GAIN_RAMP_EN
  localparam logic signed [16:0] STEP_S = $signed({1'b0, RAMP_STEP});

  logic signed [16:0] diff;

  assign diff = $signed({1'b0, eff_tgt}) - $signed({1'b0, gain_q});

  always_comb begin
    gain_d = eff_tgt;
    if (diff > STEP_S) begin
      gain_d = gain_q + RAMP_STEP;
    end else if (diff < -STEP_S) begin
      gain_d = gain_q - RAMP_STEP;
    end
  end
`else
  logic unused_ramp_step;

  assign unused_ramp_step = ^RAMP_STEP;

  always_comb begin
    gain_d = eff_tgt;
  end
`endif

  assign mul_smp = (state_q == ST_MUL1) ? smp1_q : smp2_q;

  gain_mul_sat u_mul (
    .sample_i (mul_smp),
    .gain_i   (gain_q),
    .result_o (mul_res)
  );

  // The sequence is driven by state alone, so counter jumps cannot restart it.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      smp1_q  <= '0;
      smp2_q  <= '0;
      res1_q  <= '0;
      ch1_q   <= '0;
      ch2_q   <= '0;
      gain_q  <= UNITY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cnt256_n == LOAD_CNT) begin
            smp1_q  <= ch1_in;
            smp2_q  <= ch2_in;
            gain_q  <= gain_d;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_q <= ST_MUL1;
        end
        ST_MUL1: begin
          res1_q  <= mul_res;
          state_q <= ST_MUL2;
        end
        ST_MUL2: begin
          ch1_q   <= res1_q;
          ch2_q   <= mul_res;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ch1_out  = ch1_q;
  assign ch2_out  = ch2_q;
  assign gain_cur = gain_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_gain_ramp.sv
// ============================================================================
// Module   : tb_audio_gain_ramp
// Purpose  : Randomized frame-level bench for audio_gain_ramp against a
//            behavioural gain/scale model. Honours GAIN_RAMP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_audio_gain_ramp;

  localparam logic [7:0]  L     = 8'd8;
  localparam logic [15:0] STEP  = 16'h0400;
  localparam logic [15:0] UNITY = 16'h4000;

  logic        mclk = 1'b0;
  logic        rst;
  logic [7:0]  cnt256_n;
  logic [15:0] ch1_in, ch2_in, gain_target;
  logic        mute;
  logic [15:0] ch1_out, ch2_out, gain_cur;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] gain_m = UNITY;
  logic [15:0] gprev  = UNITY;
  logic [15:0] prev1  = 16'h0;
  logic [15:0] prev2  = 16'h0;
  logic [15:0] exp1, exp2;

  always #5 mclk = ~mclk;

  audio_gain_ramp #(
    .LOAD_CNT  (L),
    .RAMP_STEP (STEP),
    .UNITY     (UNITY)
  ) dut (
    .mclk        (mclk),
    .rst         (rst),
    .cnt256_n    (cnt256_n),
    .ch1_in      (ch1_in),
    .ch2_in      (ch2_in),
    .gain_target (gain_target),
    .mute        (mute),
    .ch1_out     (ch1_out),
    .ch2_out     (ch2_out),
    .gain_cur    (gain_cur)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, expv, $time);
    end
  endtask

  // Real-valued meaning: sample * gain / 16384, rounded half up, clamped to int16.
  function automatic logic [15:0] ref_scale(input logic [15:0] s, input logic [15:0] g);
    longint p;
    logic [15:0] r;
    p = longint'($signed(s)) * longint'(g);
    p = (p + 64'sd8192) >>> 14;
    if (p > 32767)       p = 32767;
    else if (p < -32768) p = -32768;
    r = 16'(p);
    return r;
  endfunction

  function automatic logic [15:0] ref_next_gain(input logic [15:0] cur, input logic [15:0] tgt);
`ifdef GAIN_RAMP_EN
    int d;
    d = int'(tgt) - int'(cur);
    if (d > int'(STEP))  return cur + STEP;
    if (d < -int'(STEP)) return cur - STEP;
`endif
    return tgt;
  endfunction

  // mode 0: plain frame, 1: reset while in MUL1, 2: counter jumps back to LOAD_CNT mid-sequence
  task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] t,
                       input logic m, input int mode);
    ch1_in = a; ch2_in = b; gain_target = t; mute = m;
    cnt256_n = L - 8'd3;
    gain_m = ref_next_gain(gprev, m ? 16'h0000 : t);
    exp1 = ref_scale(a, gain_m);
    exp2 = ref_scale(b, gain_m);
    for (int k = 0; k < 8; k++) begin
      @(posedge mclk); #1;
      check("gain_cur", gain_cur, (k < 3) ? gprev : gain_m);
      check("ch1_out",  ch1_out,  (k < 6) ? prev1 : exp1);
      check("ch2_out",  ch2_out,  (k < 6) ? prev2 : exp2);
      if (k == 4) begin
        gain_target = 16'($urandom);
        mute        = 1'($urandom);
        if (mode == 1) begin
          rst = 1'b1;
          #1;
          check("rst_ch1",  ch1_out,  16'h0000);
          check("rst_ch2",  ch2_out,  16'h0000);
          check("rst_gain", gain_cur, UNITY);
          gain_m = UNITY; exp1 = 16'h0; exp2 = 16'h0; prev1 = 16'h0; prev2 = 16'h0;
          @(negedge mclk);
          rst = 1'b0;
        end
      end
      if (mode == 2 && k >= 4) cnt256_n = (k == 4) ? L : 8'(200 + k);
      else                     cnt256_n = cnt256_n + 8'd1;
    end
    prev1 = exp1; prev2 = exp2; gprev = gain_m;
  endtask

  task automatic idle_wrap(input int n);
    cnt256_n = L + 8'd5;
    for (int i = 0; i < n; i++) begin
      @(posedge mclk); #1;
      check("hold_ch1",  ch1_out,  prev1);
      check("hold_ch2",  ch2_out,  prev2);
      check("hold_gain", gain_cur, gprev);
      cnt256_n = cnt256_n + 8'd1;
    end
  endtask

  initial begin
    rst = 1'b1; cnt256_n = 8'd0; ch1_in = '0; ch2_in = '0; gain_target = '0; mute = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    check("reset_ch1",  ch1_out,  16'h0000);
    check("reset_ch2",  ch2_out,  16'h0000);
    check("reset_gain", gain_cur, UNITY);
    @(negedge mclk);
    rst = 1'b0;

    frame(16'h1234, 16'hEDCC, 16'h4000, 1'b0, 0);
    frame(16'h7000, 16'h9000, 16'h8000, 1'b0, 0);
    frame(16'h0003, 16'hFFFD, 16'h2000, 1'b0, 0);

    for (int i = 0; i < 16; i++) frame(16'($urandom), 16'($urandom), 16'h4000, 1'b1, 0);
    check("mute_zero", gain_cur, 16'h0000);
    for (int i = 0; i < 6; i++) frame(16'($urandom), 16'($urandom), 16'hFFFF, 1'b0, 0);

    idle_wrap(250);

    for (int i = 0; i < 30; i++) begin
      frame(16'($urandom), 16'($urandom), 16'($urandom_range(0, 16'hFFFF)),
            ($urandom_range(0, 3) == 0), (i == 10) ? 1 : (i == 20) ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
